id_ctrl_unit: RTL and testbench

- Decode-stage controller for the pipelined RV32I core.
- Decodes the IF/ID instruction and drives imm_src_d combinationally to the immediate extension unit.
- Registers the EX-stage control word into the ID/EX boundary.
- Owns load-use hazard detection and branch/jump flush bubbling, so it sequences when decoded controls and immediates advance.

---
 rtl/id_ctrl_if.sv | 44 ++++
 rtl/id_ctrl_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_id_ctrl_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/id_ctrl_if.sv
// ============================================================================
//  Module   : id_ctrl_if
//  Purpose  : IF/ID-to-controller handshake and ID/EX control word bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ctrl_if;
   logic [31:0] instr_d;
   logic        valid_d;
   logic        flush_e;
   logic [2:0]  imm_src_d;
   logic        stall_d;
   logic        valid_e;
   logic        reg_write_e;
   logic        mem_write_e;
   logic [1:0]  result_src_e;
   logic        alu_src_e;
   logic        alu_a_pc_e;
   logic [1:0]  alu_op_e;
   logic [2:0]  funct3_e;
   logic        funct7b5_e;
   logic        branch_e;
   logic        jump_e;
   logic        jalr_e;
   logic [4:0]  rd_e;
   logic        illegal_e;

   modport master (
      output instr_d, valid_d, flush_e,
      input  imm_src_d, stall_d, valid_e, reg_write_e, mem_write_e,
             result_src_e, alu_src_e, alu_a_pc_e, alu_op_e, funct3_e,
             funct7b5_e, branch_e, jump_e, jalr_e, rd_e, illegal_e
   );

   modport slave (
      input  instr_d, valid_d, flush_e,
      output imm_src_d, stall_d, valid_e, reg_write_e, mem_write_e,
             result_src_e, alu_src_e, alu_a_pc_e, alu_op_e, funct3_e,
             funct7b5_e, branch_e, jump_e, jalr_e, rd_e, illegal_e
   );
endinterface

`default_nettype wire

// File: rtl/id_ctrl_unit.sv
// ============================================================================
//  Module   : id_ctrl_unit
//  Purpose  : RV32I decode-stage controller: decode, load-use stall, ID/EX reg.
//             Optional stall counter enabled by macro ID_CTRL_STALL_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ctrl_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ctrl_if.slave         bus
`ifdef ID_CTRL_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   localparam logic [6:0] C_OP_LW    = 7'b0000011;
   localparam logic [6:0] C_OP_SW    = 7'b0100011;
   localparam logic [6:0] C_OP_R     = 7'b0110011;
   localparam logic [6:0] C_OP_IALU  = 7'b0010011;
   localparam logic [6:0] C_OP_BR    = 7'b1100011;
   localparam logic [6:0] C_OP_JAL   = 7'b1101111;
   localparam logic [6:0] C_OP_JALR  = 7'b1100111;
   localparam logic [6:0] C_OP_LUI   = 7'b0110111;
   localparam logic [6:0] C_OP_AUIPC = 7'b0010111;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic [1:0] result_src;
      logic       alu_src;
      logic       alu_a_pc;
      logic [1:0] alu_op;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       illegal;
   } ctrl_t;

   logic [6:0] w_opcode;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic [4:0] w_rd;
   ctrl_t      w_ctrl;
   logic [2:0] w_imm_src;
   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic       w_hazard;
   logic       w_stall;
   logic       w_issue;

   ctrl_t      ctrl_q,   ctrl_d;
   logic       valid_q,  valid_d;
   logic [2:0] funct3_q, funct3_d;
   logic       f7b5_q,   f7b5_d;
   logic [4:0] rd_q,     rd_d;
   logic       load_q,   load_d;

   logic       unused_instr;

   assign w_opcode     = bus.instr_d[6:0];
   assign w_rd         = bus.instr_d[11:7];
   assign w_rs1        = bus.instr_d[19:15];
   assign w_rs2        = bus.instr_d[24:20];
   assign unused_instr = ^{bus.instr_d[31], bus.instr_d[29:25]};

   always_comb begin
      w_ctrl     = '0;
      w_imm_src  = 3'b000;
      w_uses_rs1 = 1'b1;
      w_uses_rs2 = 1'b0;
      case (w_opcode)
         C_OP_LW: begin
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.result_src = 2'b01;
            w_ctrl.reg_write  = 1'b1;
         end
         C_OP_SW: begin
            w_imm_src        = 3'b001;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.mem_write = 1'b1;
            w_uses_rs2       = 1'b1;
         end
         C_OP_R: begin
            w_ctrl.alu_op    = 2'b10;
            w_ctrl.reg_write = 1'b1;
            w_uses_rs2       = 1'b1;
         end
         C_OP_IALU: begin
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.alu_op    = 2'b10;
            w_ctrl.reg_write = 1'b1;
         end
         C_OP_BR: begin
            w_imm_src     = 3'b010;
            w_ctrl.alu_op = 2'b01;
            w_ctrl.branch = 1'b1;
            w_uses_rs2    = 1'b1;
         end
         C_OP_JAL: begin
            w_imm_src         = 3'b011;
            w_ctrl.result_src = 2'b10;
            w_ctrl.jump       = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_uses_rs1        = 1'b0;
         end
         C_OP_JALR: begin
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.result_src = 2'b10;
            w_ctrl.jump       = 1'b1;
            w_ctrl.jalr       = 1'b1;
            w_ctrl.reg_write  = 1'b1;
         end
         C_OP_LUI: begin
            w_imm_src         = 3'b100;
            w_ctrl.result_src = 2'b11;
            w_ctrl.reg_write  = 1'b1;
            w_uses_rs1        = 1'b0;
         end
         C_OP_AUIPC: begin
            w_imm_src        = 3'b100;
            w_ctrl.alu_a_pc  = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_uses_rs1       = 1'b0;
         end
         default: w_ctrl.illegal = 1'b1;
      endcase
   end

   // load_q already excludes rd=x0, so matching a zero source never stalls
   assign w_hazard = bus.valid_d & load_q &
                     ((w_uses_rs1 & (w_rs1 == rd_q)) | (w_uses_rs2 & (w_rs2 == rd_q)));
   assign w_stall  = w_hazard & ~bus.flush_e;
   assign w_issue  = bus.valid_d & ~bus.flush_e & ~w_hazard;

   always_comb begin
      ctrl_d   = '0;
      valid_d  = 1'b0;
      funct3_d = 3'b000;
      f7b5_d   = 1'b0;
      rd_d     = 5'd0;
      load_d   = 1'b0;
      if (w_issue) begin
         ctrl_d   = w_ctrl;
         valid_d  = 1'b1;
         funct3_d = bus.instr_d[14:12];
         f7b5_d   = bus.instr_d[30];
         rd_d     = w_rd;
         load_d   = (w_opcode == C_OP_LW) && (w_rd != 5'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q   <= '0;
         valid_q  <= 1'b0;
         funct3_q <= 3'b000;
         f7b5_q   <= 1'b0;
         rd_q     <= 5'd0;
         load_q   <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         valid_q  <= valid_d;
         funct3_q <= funct3_d;
         f7b5_q   <= f7b5_d;
         rd_q     <= rd_d;
         load_q   <= load_d;
      end
   end

   assign bus.imm_src_d    = w_imm_src;
   assign bus.stall_d      = w_stall;
   assign bus.valid_e      = valid_q;
   assign bus.reg_write_e  = ctrl_q.reg_write;
   assign bus.mem_write_e  = ctrl_q.mem_write;
   assign bus.result_src_e = ctrl_q.result_src;
   assign bus.alu_src_e    = ctrl_q.alu_src;
   assign bus.alu_a_pc_e   = ctrl_q.alu_a_pc;
   assign bus.alu_op_e     = ctrl_q.alu_op;
   assign bus.funct3_e     = funct3_q;
   assign bus.funct7b5_e   = f7b5_q;
   assign bus.branch_e     = ctrl_q.branch;
   assign bus.jump_e       = ctrl_q.jump;
   assign bus.jalr_e       = ctrl_q.jalr;
   assign bus.rd_e         = rd_q;
   assign bus.illegal_e    = ctrl_q.illegal;

`ifdef ID_CTRL_STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating: holds at all-ones instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (w_stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = CNT_W[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ctrl_unit.sv
// ============================================================================
//  Module   : tb_id_ctrl_unit
//  Purpose  : Directed, table-driven self-checking bench for id_ctrl_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ctrl_unit;
   localparam int CNT_W = 8;

   localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_SW    = 32'h00512023; // sw x5,0(x2)
   localparam logic [31:0] I_BEQ   = 32'h00208063; // beq x1,x2,0
   localparam logic [31:0] I_JAL   = 32'h000000EF; // jal x1,0
   localparam logic [31:0] I_LUI   = 32'h000011B7; // lui x3,1
   localparam logic [31:0] I_AUIPC = 32'h00000217; // auipc x4,0
   localparam logic [31:0] I_JALR  = 32'h000100E7; // jalr x1,0(x2)
   localparam logic [31:0] I_SUB   = 32'h402083B3; // sub x7,x1,x2
   localparam logic [31:0] I_ILL   = 32'h0000007F;
   localparam logic [31:0] I_LW5   = 32'h00012283; // lw x5,0(x2)
   localparam logic [31:0] I_LW0   = 32'h00012003; // lw x0,0(x2)
   localparam logic [31:0] I_ADD   = 32'h00128333; // add x6,x5,x1
   localparam logic [31:0] I_ADD0  = 32'h00100333; // add x6,x0,x1
   localparam logic [31:0] I_LWSELF = 32'h0002A283; // lw x5,0(x5)

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ctrl_if bus();

`ifdef ID_CTRL_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   id_ctrl_unit #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus)
`ifdef ID_CTRL_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   logic [21:0] ex_now;
   assign ex_now = {bus.valid_e, bus.reg_write_e, bus.mem_write_e, bus.result_src_e,
                    bus.alu_src_e, bus.alu_a_pc_e, bus.alu_op_e, bus.funct3_e,
                    bus.funct7b5_e, bus.branch_e, bus.jump_e, bus.jalr_e,
                    bus.rd_e, bus.illegal_e};

   function automatic logic [21:0] ex(input logic v, input logic rw, input logic mw,
                                      input logic [1:0] rs, input logic as, input logic apc,
                                      input logic [1:0] aop, input logic [2:0] f3,
                                      input logic f7, input logic br, input logic j,
                                      input logic jr, input logic [4:0] rd, input logic ill);
      return {v, rw, mw, rs, as, apc, aop, f3, f7, br, j, jr, rd, ill};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic v, input logic fl);
      bus.instr_d = instr;
      bus.valid_d = v;
      bus.flush_e = fl;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        flush;
      logic [2:0]  imm;
      logic        stall;
      logic [21:0] ex;
   } vec_t;

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{I_ADDI,  1'b1, 1'b0, 3'b000, 1'b0, ex(1,1,0,2'b00,1,0,2'b10,3'b000,0,0,0,0,5'd1,0)};
      tbl[1]  = '{I_SW,    1'b1, 1'b0, 3'b001, 1'b0, ex(1,0,1,2'b00,1,0,2'b00,3'b010,0,0,0,0,5'd0,0)};
      tbl[2]  = '{I_BEQ,   1'b1, 1'b0, 3'b010, 1'b0, ex(1,0,0,2'b00,0,0,2'b01,3'b000,0,1,0,0,5'd0,0)};
      tbl[3]  = '{I_JAL,   1'b1, 1'b0, 3'b011, 1'b0, ex(1,1,0,2'b10,0,0,2'b00,3'b000,0,0,1,0,5'd1,0)};
      tbl[4]  = '{I_LUI,   1'b1, 1'b0, 3'b100, 1'b0, ex(1,1,0,2'b11,0,0,2'b00,3'b001,0,0,0,0,5'd3,0)};
      tbl[5]  = '{I_AUIPC, 1'b1, 1'b0, 3'b100, 1'b0, ex(1,1,0,2'b00,1,1,2'b00,3'b000,0,0,0,0,5'd4,0)};
      tbl[6]  = '{I_JALR,  1'b1, 1'b0, 3'b000, 1'b0, ex(1,1,0,2'b10,1,0,2'b00,3'b000,0,0,1,1,5'd1,0)};
      tbl[7]  = '{I_SUB,   1'b1, 1'b0, 3'b000, 1'b0, ex(1,1,0,2'b00,0,0,2'b10,3'b000,1,0,0,0,5'd7,0)};
      tbl[8]  = '{I_ILL,   1'b1, 1'b0, 3'b000, 1'b0, ex(1,0,0,2'b00,0,0,2'b00,3'b000,0,0,0,0,5'd0,1)};
      tbl[9]  = '{I_ADDI,  1'b0, 1'b0, 3'b000, 1'b0, 22'd0};
      tbl[10] = '{I_ADDI,  1'b1, 1'b1, 3'b000, 1'b0, 22'd0};
      tbl[11] = '{I_LW5,   1'b1, 1'b0, 3'b000, 1'b0, ex(1,1,0,2'b01,1,0,2'b00,3'b010,0,0,0,0,5'd5,0)};
      tbl[12] = '{I_ADDI,  1'b1, 1'b0, 3'b000, 1'b0, ex(1,1,0,2'b00,1,0,2'b10,3'b000,0,0,0,0,5'd1,0)};

      // Reset state while inputs present a valid instruction
      rst_n = 1'b0;
      drive(I_ADDI, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex", {10'd0, ex_now}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall_d}, 32'd0);
      @(negedge clk);
      drive(I_ADDI, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(tbl[i].instr, tbl[i].valid, tbl[i].flush);
         #1;
         chk($sformatf("v%0d_imm", i), {29'd0, bus.imm_src_d}, {29'd0, tbl[i].imm});
         chk($sformatf("v%0d_stall", i), {31'd0, bus.stall_d}, {31'd0, tbl[i].stall});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ex", i), {10'd0, ex_now}, {10'd0, tbl[i].ex});
      end

      // Load-use: exactly one stall, one bubble, then the dependent add issues
      @(negedge clk); drive(I_LW5, 1'b1, 1'b0);
      @(negedge clk); drive(I_ADD, 1'b1, 1'b0);
      #1 chk("lu_stall", {31'd0, bus.stall_d}, 32'd1);
      @(posedge clk); #1 chk("lu_bubble", {31'd0, bus.valid_e}, 32'd0);
      @(negedge clk); #1 chk("lu_stall_once", {31'd0, bus.stall_d}, 32'd0);
      @(posedge clk); #1 chk("lu_issue", {10'd0, ex_now},
                             {10'd0, ex(1,1,0,2'b00,0,0,2'b10,3'b000,0,0,0,0,5'd6,0)});

      // Load to x0 never stalls, even against an x0 source
      @(negedge clk); drive(I_LW0, 1'b1, 1'b0);
      @(negedge clk); drive(I_ADD0, 1'b1, 1'b0);
      #1 chk("x0_stall", {31'd0, bus.stall_d}, 32'd0);
      @(posedge clk); #1 chk("x0_issue", {26'd0, bus.valid_e, bus.rd_e}, {26'd0, 1'b1, 5'd6});

      // Flush beats a simultaneous load-use hazard
      @(negedge clk); drive(I_LW5, 1'b1, 1'b0);
      @(negedge clk); drive(I_ADD, 1'b1, 1'b1);
      #1 chk("fl_stall", {31'd0, bus.stall_d}, 32'd0);
      @(posedge clk); #1 chk("fl_bubble", {10'd0, ex_now}, 32'd0);
      @(negedge clk); drive(I_ADD, 1'b1, 1'b0);
      #1 chk("fl_after_stall", {31'd0, bus.stall_d}, 32'd0);

      // Reset in the middle of a stall
      @(negedge clk); drive(I_LW5, 1'b1, 1'b0);
      @(negedge clk); drive(I_ADD, 1'b1, 1'b0);
      #1 chk("rs_stall_pre", {31'd0, bus.stall_d}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rs_stall", {31'd0, bus.stall_d}, 32'd0);
      chk("rs_ex", {10'd0, ex_now}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(I_ADDI, 1'b1, 1'b0);
      @(posedge clk); #1 chk("rs_first", {10'd0, ex_now},
                             {10'd0, ex(1,1,0,2'b00,1,0,2'b10,3'b000,0,0,0,0,5'd1,0)});

`ifdef ID_CTRL_STALL_CNT_EN
      // Self-dependent load stalls every other cycle
      @(negedge clk);
      rst_n = 1'b0;
      drive(I_LWSELF, 1'b1, 1'b0);
      #1 chk("cnt_rst0", {24'd0, stall_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("cnt_10", {24'd0, stall_cnt}, 32'd5);
      repeat (610) @(posedge clk);
      #1 chk("cnt_sat", {24'd0, stall_cnt}, 32'd255);
      rst_n = 1'b0;
      #1 chk("cnt_clr", {24'd0, stall_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

`default_nettype wire
